// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if
//   Groups the request and response channels of the shared adder.
//   master : client side (drives requests, accepts responses)
//   slave  : arbiter side (grants requests, returns results)
//   req_valid/req_ready : per-requester handshake, one bit per requester
//   req_a/req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin             : per-requester carry-in
//   rsp_*               : result channel tagged with the issuing requester
//   busy                : arbiter is computing or holding a result
interface adder_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Shares one CHUNK-bits-per-cycle adder among NUM_REQ requesters.
//   A round-robin arbiter grants one request in IDLE, the operands are
//   added over SLICES cycles with a registered carry, and the result is
//   offered on a valid/ready response channel tagged with the requester id.
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset
//     bus : adder_share_arbiter_if.slave (request/response channels, busy)
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CHUNK   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_share_arbiter_if.slave  bus
);

  localparam int SLICES = WIDTH / CHUNK;
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int K_W    = (SLICES > 1) ? $clog2(SLICES) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_chunk_check
      $error("adder_share_arbiter: WIDTH must be a multiple of CHUNK");
    end
    if (NUM_REQ < 2) begin : g_req_check
      $error("adder_share_arbiter: NUM_REQ must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     ptr_reg;
  logic [K_W-1:0]      k_reg;
  logic [WIDTH-1:0]    a_reg, b_reg;
  logic                carry_reg;
  logic [WIDTH-1:0]    sum_reg;
  logic                cout_reg;
  logic [ID_W-1:0]     id_reg;

  // Unpacked view of the per-requester operands.
  logic [WIDTH-1:0]    a_vec [NUM_REQ];
  logic [WIDTH-1:0]    b_vec [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_vec[gi] = bus.req_a[gi*WIDTH +: WIDTH];
    assign b_vec[gi] = bus.req_b[gi*WIDTH +: WIDTH];
  end

  // Round-robin search: first valid requester at or above ptr, wrapping.
  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [ID_W:0]   idx_w;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx_w       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_w = {1'b0, ptr_reg} + (ID_W+1)'(i);
      if (idx_w >= (ID_W+1)'(NUM_REQ)) begin
        idx_w = idx_w - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && bus.req_valid[idx_w[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx_w[ID_W-1:0];
      end
    end
  end

  logic [ID_W-1:0] ptr_after_grant;
  assign ptr_after_grant = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);

  // FSM: next state and grant.
  logic [NUM_REQ-1:0] req_ready_c;
  logic               accept;
  logic               last_slice;

  assign last_slice = (k_reg == K_W'(SLICES-1));

  always_comb begin
    state_next  = state_reg;
    req_ready_c = '0;
    accept      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Grant is suppressed while rst is high so nothing looks accepted.
        if (!rst && grant_found) begin
          req_ready_c[grant_id] = 1'b1;
          accept                = 1'b1;
          state_next            = S_BUSY;
        end
      end
      S_BUSY: begin
        if (last_slice) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // One CHUNK-wide slice of the add. Operands shift right each cycle so the
  // active slice is always the low CHUNK bits; the sum fills from the top.
  logic [CHUNK:0]   slice_full;
  logic [WIDTH-1:0] sum_shifted;

  assign slice_full  = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                     + (CHUNK+1)'(carry_reg);
  assign sum_shifted = (sum_reg >> CHUNK)
                     | (WIDTH'(slice_full[CHUNK-1:0]) << (WIDTH - CHUNK));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg   <= '0;
      k_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      id_reg    <= '0;
    end else begin
      if (accept) begin
        a_reg     <= a_vec[grant_id];
        b_reg     <= b_vec[grant_id];
        carry_reg <= bus.req_cin[grant_id];
        id_reg    <= grant_id;
        k_reg     <= '0;
        ptr_reg   <= ptr_after_grant;
      end else if (state_reg == S_BUSY) begin
        a_reg     <= a_reg >> CHUNK;
        b_reg     <= b_reg >> CHUNK;
        carry_reg <= slice_full[CHUNK];
        sum_reg   <= sum_shifted;
        if (last_slice) begin
          k_reg    <= '0;
          cout_reg <= slice_full[CHUNK];
        end else begin
          k_reg <= k_reg + K_W'(1);
        end
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = (state_reg == S_DONE);
  assign bus.rsp_sum   = sum_reg;
  assign bus.rsp_cout  = cout_reg;
  assign bus.rsp_id    = id_reg;
  assign bus.busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int CHUNK   = 2;
  localparam int TMO     = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  adder_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic exp_t model(int id, logic [7:0] a, logic [7:0] b, logic cin);
    logic [8:0] t;
    exp_t e;
    t      = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    e.id   = 2'(id);
    e.sum  = t[7:0];
    e.cout = t[8];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int id, logic [7:0] a, logic [7:0] b, logic cin);
    bus.req_a[id*WIDTH +: WIDTH] = a;
    bus.req_b[id*WIDTH +: WIDTH] = b;
    bus.req_cin[id]              = cin;
    bus.req_valid[id]            = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < TMO && !ok; c++) begin
      #1;
      if (|bus.req_ready) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < TMO && !ok; c++) begin
      if (bus.rsp_valid === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  // Raise one request, wait for its grant, pass the accept edge, drop it.
  task automatic issue(int id, logic [7:0] a, logic [7:0] b, logic cin,
                       output logic [3:0] rdy, output bit ok);
    set_req(id, a, b, cin);
    sb.push_back(model(id, a, b, cin));
    wait_ready(ok);
    rdy = bus.req_ready;
    tick();
    bus.req_valid[id] = 1'b0;
  endtask

  // Wait for a response, capture it, pass the handshake edge.
  task automatic collect(output exp_t got, output bit ok);
    wait_rsp(ok);
    got = {bus.rsp_id, bus.rsp_sum, bus.rsp_cout};
    $display("txn id=%0d sum=%02h cout=%0b", got.id, got.sum, got.cout);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    repeat (3) tick();
    #1;
    vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.rsp_sum !== 8'h00) begin miscompares++; $display("FAIL reset_rsp_sum: got %h want 00", bus.rsp_sum); end
    vectors++; if (bus.rsp_cout !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_cout: got %b want 0", bus.rsp_cout); end
    vectors++; if (bus.rsp_id !== 2'd0) begin miscompares++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
    bus.req_valid = '0;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_single_overflow();
    int   lat;
    exp_t exp_v, got;
    tick();
    bus.rsp_ready = 1'b1;
    set_req(0, 8'hFF, 8'h01, 1'b0);
    sb.push_back(model(0, 8'hFF, 8'h01, 1'b0));
    #1;
    vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL single_grant: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      tick();
      if (bus.rsp_valid === 1'b1) lat = c;
    end
    vectors++; if (lat != 4) begin miscompares++; $display("FAIL single_latency: got %0d want 4", lat); end
    got   = {bus.rsp_id, bus.rsp_sum, bus.rsp_cout};
    exp_v = sb.pop_front();
    $display("txn id=%0d sum=%02h cout=%0b", got.id, got.sum, got.cout);
    vectors++; if (got !== exp_v) begin miscompares++; $display("FAIL single_result: got %h want %h", got, exp_v); end
    tick();
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_one_cycle: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_carry_in();
    logic [7:0] av [2] = '{8'h7F, 8'h35};
    logic [7:0] bv [2] = '{8'h80, 8'h4A};
    logic       cv [2] = '{1'b1, 1'b0};
    logic [3:0] rdy;
    bit         ok;
    exp_t       exp_v, got;
    for (int n = 0; n < 2; n++) begin
      issue(2, av[n], bv[n], cv[n], rdy, ok);
      vectors++; if (!ok || rdy !== 4'b0100) begin miscompares++; $display("FAIL carry_grant%0d: got %b want 0100", n, rdy); end
      collect(got, ok);
      exp_v = sb.pop_front();
      vectors++; if (!ok || got !== exp_v) begin miscompares++; $display("FAIL carry_result%0d: got %h want %h (ok=%0b)", n, got, exp_v, ok); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] oa [4] = '{8'h11, 8'hC8, 8'h9D, 8'hF0};
    logic [7:0] ob [4] = '{8'h22, 8'h47, 8'h63, 8'h1F};
    logic       oc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int         order [5] = '{0, 1, 2, 3, 0};
    bit         ok;
    exp_t       exp_v, got;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, oa[i], ob[i], oc[i]);
    for (int n = 0; n < 5; n++) begin
      sb.push_back(model(order[n], oa[order[n]], ob[order[n]], oc[order[n]]));
      wait_ready(ok);
      vectors++; if (!ok || bus.req_ready !== 4'(1 << order[n])) begin miscompares++; $display("FAIL simul_grant%0d: got %b want %b", n, bus.req_ready, 4'(1 << order[n])); end
      tick();
      collect(got, ok);
      exp_v = sb.pop_front();
      vectors++; if (!ok || got !== exp_v) begin miscompares++; $display("FAIL simul_result%0d: got %h want %h (ok=%0b)", n, got, exp_v, ok); end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [3:0] rdy;
    bit         ok;
    exp_t       exp_v, got;
    bus.rsp_ready = 1'b0;
    issue(1, 8'hA5, 8'h6E, 1'b1, rdy, ok);
    vectors++; if (!ok || rdy !== 4'b0010) begin miscompares++; $display("FAIL bp_grant: got %b want 0010", rdy); end
    exp_v = sb.pop_front();
    wait_rsp(ok);
    got = {bus.rsp_id, bus.rsp_sum, bus.rsp_cout};
    $display("txn id=%0d sum=%02h cout=%0b", got.id, got.sum, got.cout);
    vectors++; if (!ok || got !== exp_v) begin miscompares++; $display("FAIL bp_result: got %h want %h (ok=%0b)", got, exp_v, ok); end
    set_req(3, 8'h01, 8'h02, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      got = {bus.rsp_id, bus.rsp_sum, bus.rsp_cout};
      vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid%0d: got %b want 1", c, bus.rsp_valid); end
      vectors++; if (got !== exp_v) begin miscompares++; $display("FAIL bp_stable%0d: got %h want %h", c, got, exp_v); end
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy%0d: got %b want 1", c, bus.busy); end
      vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_req_ready%0d: got %b want 0000", c, bus.req_ready); end
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    vectors++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL bp_release: got valid=%b busy=%b want 0 0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_reset_mid_busy();
    logic [3:0] rdy;
    bit         ok;
    int         seen;
    exp_t       exp_v, got;
    issue(2, 8'hC3, 8'h5A, 1'b1, rdy, ok);
    vectors++; if (!ok || rdy !== 4'b0100) begin miscompares++; $display("FAIL rmb_grant: got %b want 0100", rdy); end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rmb_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rmb_valid: got %b want 0", bus.rsp_valid); end
    vectors++; if ({bus.rsp_id, bus.rsp_sum, bus.rsp_cout} !== 11'd0) begin miscompares++; $display("FAIL rmb_outputs: got id=%0d sum=%h cout=%b want all 0", bus.rsp_id, bus.rsp_sum, bus.rsp_cout); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL rmb_no_rsp: got %0d valid cycles want 0", seen); end
    set_req(3, 8'h10, 8'h20, 1'b0);
    set_req(0, 8'h3C, 8'hC4, 1'b1);
    sb.push_back(model(0, 8'h3C, 8'hC4, 1'b1));
    #1;
    vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL rmb_ptr_reset: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    collect(got, ok);
    exp_v = sb.pop_front();
    vectors++; if (!ok || got !== exp_v) begin miscompares++; $display("FAIL rmb_result: got %h want %h (ok=%0b)", got, exp_v, ok); end
  endtask

  task automatic test_round_robin();
    logic [7:0] oa [4] = '{8'h00, 8'h81, 8'hFE, 8'h55};
    logic [7:0] ob [4] = '{8'h00, 8'h7F, 8'h03, 8'hAA};
    logic       oc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int         order [5] = '{1, 2, 1, 2, 3};
    bit         ok;
    exp_t       exp_v, got;
    do_reset();
    set_req(1, oa[1], ob[1], oc[1]);
    set_req(2, oa[2], ob[2], oc[2]);
    for (int n = 0; n < 5; n++) begin
      sb.push_back(model(order[n], oa[order[n]], ob[order[n]], oc[order[n]]));
      wait_ready(ok);
      vectors++; if (!ok || bus.req_ready !== 4'(1 << order[n])) begin miscompares++; $display("FAIL rr_grant%0d: got %b want %b", n, bus.req_ready, 4'(1 << order[n])); end
      tick();
      if (n == 2) set_req(3, oa[3], ob[3], oc[3]);
      collect(got, ok);
      exp_v = sb.pop_front();
      vectors++; if (!ok || got !== exp_v) begin miscompares++; $display("FAIL rr_result%0d: got %h want %h (ok=%0b)", n, got, exp_v, ok); end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_random();
    logic [3:0] rdy;
    bit         ok;
    int         id;
    logic [7:0] a, b;
    logic       cin;
    exp_t       exp_v, got;
    for (int n = 0; n < 10; n++) begin
      id  = $urandom_range(0, NUM_REQ-1);
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      issue(id, a, b, cin, rdy, ok);
      vectors++; if (!ok || rdy !== 4'(1 << id)) begin miscompares++; $display("FAIL rand_grant%0d: got %b want %b", n, rdy, 4'(1 << id)); end
      collect(got, ok);
      exp_v = sb.pop_front();
      vectors++; if (!ok || got !== exp_v) begin miscompares++; $display("FAIL rand_result%0d: got %h want %h (ok=%0b)", n, got, exp_v, ok); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single_overflow();
    test_carry_in();
    test_simultaneous();
    test_backpressure();
    test_reset_mid_busy();
    test_round_robin();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Shares one sliced (multi-cycle) adder datapath among NUM_REQ requesters. A round-robin arbiter grants one request at a time. The operation runs CHUNK bits per cycle with a registered carry chain, and the result is returned over a valid/ready response channel tagged with the requester index. The block sits between the adder-consuming clients and the shared adder core, and is the sequencing point for the adder verification bench.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- WIDTH, 8, operand/sum width in bits
- CHUNK, 2, bits added per cycle. WIDTH % CHUNK != 0 is an elaboration error. SLICES = WIDTH/CHUNK.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept, at most one bit high
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- req_cin  in  NUM_REQ  carry-in per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  WIDTH  sum
- rsp_cout  out  1  carry-out of bit WIDTH-1
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that issued the operation
- busy  out  1  high in BUSY or DONE

## Operation
State machine: IDLE, BUSY, DONE.

- **IDLE**
  - req_ready[g] = 1 combinationally for g = first index with req_valid set, searching from ptr upward with wrap-around. All other req_ready bits are 0.
  - No valid requests: all req_ready = 0 and the state stays IDLE.
  - Accept = req_valid[g] & req_ready[g]. On accept:
    - latch A, B and cin into carry.
    - latch id = g.
    - slice counter k = 0.
    - ptr ← (g+1) mod NUM_REQ.
    - go to BUSY.
- **BUSY**
  - Each cycle: {carry, sum[k*CHUNK +: CHUNK]} ← A_slice + B_slice + carry, where A_slice and B_slice are bits [k*CHUNK +: CHUNK] of the latched operands.
  - k increments each cycle.
  - After slice SLICES-1: go to DONE and set rsp_cout ← final carry.
  - req_ready is all 0.
- **DONE**
  - rsp_valid = 1. rsp_sum, rsp_cout and rsp_id are held stable.
  - On rsp_valid & rsp_ready: go to IDLE.
  - req_ready is all 0.
- Arithmetic is unsigned and modulo 2^WIDTH. The carry chain is exact and equal to a full WIDTH-bit add with cin.
- Requests are sampled only in IDLE. A request dropped before its grant is simply not served.
- Operands of non-granted requesters are ignored.

## Timing
- Reset (rst = 1 at an edge), from the next cycle, regardless of state:
  - state = IDLE, ptr = 0, k = 0.
  - rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0, busy = 0.
  - req_ready = 0 while rst is high.
- Reset mid-operation abandons the operation. No response is emitted for it.
- Latency:
  - Accept at edge T0.
  - BUSY during cycles T0+1 … T0+SLICES.
  - rsp_valid = 1 from the cycle after edge T0+SLICES.
  - With the defaults, rsp_valid is high 4 cycles after the accept edge.
- Response handshake at edge T1 → IDLE in cycle T1+1. The earliest next accept is edge T1+1.
- Minimum issue interval: SLICES+2 cycles.
- Backpressure: rsp_ready low holds DONE indefinitely. Outputs stay stable and no request is accepted.
- Fairness: a continuously-valid requester waits at most NUM_REQ-1 other operations.

## Test plan
1. **Single request, overflow.** Reset, then requester 0 sends a=0xFF, b=0x01, cin=0, rsp_ready=1.
   - Expect req_ready[0] in the same cycle.
   - rsp_valid exactly 4 cycles after the accept edge, with sum=0x00, cout=1, id=0.
   - rsp_valid is high for one cycle.
2. **Carry-in through all slices.** Requester 2 sends a=0x7F, b=0x80, cin=1.
   - Expect sum=0x00, cout=1, id=2.
   - Also a=0x35, b=0x4A, cin=0 → sum=0x7F, cout=0.
3. **Simultaneous requests after reset.** All four requesters are valid with distinct operands and stay valid.
   - Grant order 0, 1, 2, 3, then 0.
   - rsp_id follows the same order and each sum is correct.
4. **Backpressure.** Hold rsp_ready=0 for 5 cycles in DONE.
   - rsp_valid, rsp_sum, rsp_cout and rsp_id stay stable; busy=1; all req_ready=0.
   - Raise rsp_ready → handshake, then IDLE on the next cycle.
5. **Reset mid-BUSY.** Assert rst at slice k=2.
   - Next cycle: busy=0, rsp_valid=0, outputs zero, and no response is ever emitted for the abandoned operation.
   - Then requesters 3 and 0 valid → requester 0 granted (ptr reset to 0).
6. **Round-robin pair.** Requesters 1 and 2 are continuously valid.
   - Grants alternate 1, 2, 1, 2.
   - Requester 3 raised mid-sequence is granted within 2 operations.
